alu_op_dispatcher: RTL and testbench
====================================

Name: alu_op_dispatcher

Overview:
- Upstream command stage for the 8-bit adder/subtractor unit.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the unit by driving Opcode/A/B/Select, holding them stable for a fixed number of cycles.
- Captures the unit's result and flag, then returns a response over a second valid/ready interface, one operation at a time.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, ≥2.
- HOLD_CYCLES, 2, Clk edges for which operands/Select are held before capture; ≥1.
- UNIT_SEL, 3'b001, Select code that enables the adder/subtractor.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_opcode  in  4  operation code.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- Opcode  out  4  to unit.
- A  out  8  to unit.
- B  out  8  to unit.
- Select  out  3  to unit; UNIT_SEL while issuing, else 0.
- Unit_Result  in  8  unit result register.
- Unit_Flag  in  1  unit flag (1 = supported op executed).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  8  captured result.
- rsp_opcode  out  4  opcode of the response.
- rsp_error  out  1  ~Unit_Flag at capture.
- busy  out  1  FSM not IDLE.
- cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, active-high): all outputs 0, FIFO pointers/count 0, FSM = IDLE, hold counter 0. Reset mid-operation discards the in-flight op and all queued commands; no response is produced.
- All outputs are registered, except cmd_ready = (cmd_count < DEPTH), which is combinational from the count.
- Push: on cmd_valid && cmd_ready at a rising edge, write {opcode,a,b} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Full: cmd_ready = 0 even when a pop occurs in the same cycle; no bypass.
- Simultaneous push and pop: count unchanged.
- Pop occurs only in IDLE with count > 0.
- Opcodes are not filtered. Any 4-bit opcode is dispatched; unsupported codes return rsp_error = 1 with rsp_result = Unit_Result (0 from the unit).
- FSM:
  - IDLE: if count > 0, pop the head at the edge; load Opcode/A/B/rsp_opcode; Select ← UNIT_SEL; hold counter ← 0; → ISSUE.
  - ISSUE: Opcode/A/B/Select stable; counter increments each edge; on the edge where counter == HOLD_CYCLES-1 → CAPTURE.
  - CAPTURE: one cycle; at its edge rsp_result ← Unit_Result, rsp_error ← ~Unit_Flag, rsp_valid ← 1, Select ← 0 → RESPOND.
  - RESPOND: outputs held. On an edge with rsp_ready = 1: rsp_valid ← 0 → IDLE. rsp_ready high for many cycles produces exactly one handshake per op.
- Latency: command accepted into an empty FIFO, idle FSM at edge t → rsp_valid high after edge t+HOLD_CYCLES+2 (t+4 at default).
- Throughput: with rsp_ready held at 1, one op per HOLD_CYCLES+3 cycles.
- A/B/Opcode keep their last values after issue; only Select returns to 0.
- busy = 1 in ISSUE, CAPTURE and RESPOND.

Test Plan:
- Reset, then ADD (opcode 4'h2, A=8'h25, B=8'h13) at edge t, rsp_ready = 1 → rsp_valid at t+4, rsp_result = 8'h38, rsp_error = 0, rsp_opcode = 4'h2; Select = 3'b001 for exactly cycles t+1..t+3.
- SUB (4'h3, A=8'h10, B=8'h20) → rsp_result = 8'hF0, rsp_error = 0; a following ADD 8'hFF+8'h01 → 8'h00 (wrap), error 0.
- Hold rsp_ready = 0, offer 6 back-to-back commands → first issued, cmd_ready drops once cmd_count reaches 4, 5 of 6 accepted, Select = 0 while stalled in RESPOND. Release rsp_ready → responses return in order with correct opcodes, the 6th command is accepted when space frees, and pointers wrap correctly.
- Opcode 4'hA, A=8'h55 → rsp_error = 1, rsp_result = 8'h00; the next valid ADD returns error 0.
- Assert Reset during ISSUE with 3 queued → all outputs 0 immediately (async), cmd_count = 0, no rsp_valid after release; a new command completes normally at t+4.
- Re-run the first ADD scenario with HOLD_CYCLES = 1 and HOLD_CYCLES = 4 → rsp_valid at t+3 and t+6 respectively, same result.

Source files
------------

// File: rtl/alu_op_dispatcher.sv
// ---------------------------------------------------------------------------
// alu_op_dispatcher
//
// Upstream command stage for the 8-bit adder/subtractor unit. Commands arrive
// over a valid/ready interface and are queued in a small FIFO. One command at
// a time is issued to the unit: Opcode/A/B are driven and Select enables the
// unit for HOLD_CYCLES clock edges. The unit's registered result and flag are
// then captured and offered over a second valid/ready interface. The next
// command is popped only after that response has been accepted.
//
// Parameters
//   DEPTH        command FIFO entries (power of two, >= 2)
//   HOLD_CYCLES  edges for which operands/Select are held before capture (>= 1)
//   UNIT_SEL     Select code that enables the adder/subtractor
//
// Ports
//   Clk, Reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is combinational from
//                         the FIFO occupancy (no bypass when full)
//   cmd_opcode/a/b        command payload
//   Opcode/A/B/Select     drive to the unit; Select is UNIT_SEL while issuing
//   Unit_Result/Unit_Flag unit result register and "op supported" flag
//   rsp_valid/rsp_ready   response handshake
//   rsp_result/opcode     captured result and the opcode it belongs to
//   rsp_error             ~Unit_Flag at capture time
//   busy                  FSM is not idle
//   cmd_count             FIFO occupancy
// ---------------------------------------------------------------------------
module alu_op_dispatcher #(
  parameter int         DEPTH       = 4,
  parameter int         HOLD_CYCLES = 2,
  parameter logic [2:0] UNIT_SEL    = 3'b001
) (
  input  logic                     Clk,
  input  logic                     Reset,
  // command interface
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  // unit interface
  output logic [3:0]               Opcode,
  output logic [7:0]               A,
  output logic [7:0]               B,
  output logic [2:0]               Select,
  input  logic [7:0]               Unit_Result,
  input  logic                     Unit_Flag,
  // response interface
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic [3:0]               rsp_opcode,
  output logic                     rsp_error,
  // status
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 4 + 8 + 8;
  // Counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head_entry;
  logic [3:0]         head_opcode;
  logic [7:0]         head_a;
  logic [7:0]         head_b;

  state_t             state_reg;
  state_t             state_next;

  // Full blocks a push even if the FSM pops in the same cycle: ready depends
  // only on the registered count, never on the pop decision.
  assign cmd_ready = (count_reg < FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);

  // Payload storage carries no reset; only pointers and count define contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  // The head is read combinationally so the pop edge can load the unit
  // operands directly.
  assign head_entry  = fifo_mem[rd_ptr_reg];
  assign head_opcode = head_entry[19:16];
  assign head_a      = head_entry[15:8];
  assign head_b      = head_entry[7:0];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Issue / capture / respond FSM
  // -------------------------------------------------------------------------
  logic [HOLD_W-1:0] hold_reg,       hold_next;
  logic [3:0]        opcode_reg,     opcode_next;
  logic [7:0]        a_reg,          a_next;
  logic [7:0]        b_reg,          b_next;
  logic [2:0]        select_reg,     select_next;
  logic              rsp_valid_reg,  rsp_valid_next;
  logic [7:0]        rsp_result_reg, rsp_result_next;
  logic [3:0]        rsp_opcode_reg, rsp_opcode_next;
  logic              rsp_error_reg,  rsp_error_next;
  logic              busy_reg,       busy_next;

  always_comb begin
    state_next      = state_reg;
    hold_next       = hold_reg;
    opcode_next     = opcode_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    select_next     = select_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_result_next = rsp_result_reg;
    rsp_opcode_next = rsp_opcode_reg;
    rsp_error_next  = rsp_error_reg;

    case (state_reg)
      IDLE: begin
        if (pop) begin
          opcode_next     = head_opcode;
          a_next          = head_a;
          b_next          = head_b;
          rsp_opcode_next = head_opcode;
          select_next     = UNIT_SEL;
          hold_next       = '0;
          state_next      = ISSUE;
        end
      end

      ISSUE: begin
        // The unit registers its result while Select is asserted; after
        // HOLD_CYCLES edges of stable operands the result is settled.
        if (hold_reg == HOLD_LAST) begin
          hold_next  = '0;
          state_next = CAPTURE;
        end else begin
          hold_next  = hold_reg + 1'b1;
        end
      end

      CAPTURE: begin
        rsp_result_next = Unit_Result;
        rsp_error_next  = ~Unit_Flag;
        rsp_valid_next  = 1'b1;
        select_next     = '0;
        state_next      = RESPOND;
      end

      RESPOND: begin
        // Leaving RESPOND on the handshake edge guarantees one handshake per
        // operation even when rsp_ready stays high.
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered from the next state so busy tracks state_reg exactly.
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      hold_reg       <= '0;
      opcode_reg     <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      select_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_opcode_reg <= '0;
      rsp_error_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      opcode_reg     <= opcode_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      select_reg     <= select_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_result_reg <= rsp_result_next;
      rsp_opcode_reg <= rsp_opcode_next;
      rsp_error_reg  <= rsp_error_next;
      busy_reg       <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Opcode     = opcode_reg;
  assign A          = a_reg;
  assign B          = b_reg;
  assign Select     = select_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_opcode = rsp_opcode_reg;
  assign rsp_error  = rsp_error_reg;
  assign busy       = busy_reg;
  assign cmd_count  = count_reg;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_alu_op_dispatcher
//
// Self-checking bench for alu_op_dispatcher. Three instances share the
// clock, reset, command payload and rsp_ready: the main one at default
// HOLD_CYCLES (2) plus HOLD_CYCLES = 1 and 4 variants for latency checks.
// Each instance drives a small behavioural adder/subtractor model.
// ---------------------------------------------------------------------------
module tb_alu_op_dispatcher;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_ready;

  // per-instance signals: _m (HOLD 2), _h1 (HOLD 1), _h4 (HOLD 4)
  logic       cv_m, cr_m, rv_m, re_m, busy_m, uf_m;
  logic [3:0] op_m, ro_m;
  logic [7:0] a_m, b_m, rr_m, ur_m;
  logic [2:0] sel_m, cnt_m;
  logic       cv_h1, cr_h1, rv_h1, re_h1, busy_h1, uf_h1;
  logic [3:0] op_h1, ro_h1;
  logic [7:0] a_h1, b_h1, rr_h1, ur_h1;
  logic [2:0] sel_h1, cnt_h1;
  logic       cv_h4, cr_h4, rv_h4, re_h4, busy_h4, uf_h4;
  logic [3:0] op_h4, ro_h4;
  logic [7:0] a_h4, b_h4, rr_h4, ur_h4;
  logic [2:0] sel_h4, cnt_h4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  alu_op_dispatcher #(.DEPTH(4), .HOLD_CYCLES(2), .UNIT_SEL(3'b001)) dut_m (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cv_m), .cmd_ready(cr_m),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .Opcode(op_m), .A(a_m), .B(b_m), .Select(sel_m),
    .Unit_Result(ur_m), .Unit_Flag(uf_m),
    .rsp_valid(rv_m), .rsp_ready(rsp_ready), .rsp_result(rr_m),
    .rsp_opcode(ro_m), .rsp_error(re_m), .busy(busy_m), .cmd_count(cnt_m));

  alu_op_dispatcher #(.DEPTH(4), .HOLD_CYCLES(1), .UNIT_SEL(3'b001)) dut_h1 (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cv_h1), .cmd_ready(cr_h1),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .Opcode(op_h1), .A(a_h1), .B(b_h1), .Select(sel_h1),
    .Unit_Result(ur_h1), .Unit_Flag(uf_h1),
    .rsp_valid(rv_h1), .rsp_ready(rsp_ready), .rsp_result(rr_h1),
    .rsp_opcode(ro_h1), .rsp_error(re_h1), .busy(busy_h1), .cmd_count(cnt_h1));

  alu_op_dispatcher #(.DEPTH(4), .HOLD_CYCLES(4), .UNIT_SEL(3'b001)) dut_h4 (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cv_h4), .cmd_ready(cr_h4),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .Opcode(op_h4), .A(a_h4), .B(b_h4), .Select(sel_h4),
    .Unit_Result(ur_h4), .Unit_Flag(uf_h4),
    .rsp_valid(rv_h4), .rsp_ready(rsp_ready), .rsp_result(rr_h4),
    .rsp_opcode(ro_h4), .rsp_error(re_h4), .busy(busy_h4), .cmd_count(cnt_h4));

  // ---------------- adder/subtractor unit model ----------------
  function automatic logic [7:0] unit_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 4'h2) return a + b;
    if (op == 4'h3) return a - b;
    return 8'h00;
  endfunction

  function automatic logic unit_ok(input logic [3:0] op);
    return (op == 4'h2) || (op == 4'h3);
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ur_m <= '0; uf_m <= 1'b0; ur_h1 <= '0; uf_h1 <= 1'b0; ur_h4 <= '0; uf_h4 <= 1'b0;
    end else begin
      if (sel_m == 3'b001)  begin ur_m  <= unit_res(op_m, a_m, b_m);    uf_m  <= unit_ok(op_m);  end
      if (sel_h1 == 3'b001) begin ur_h1 <= unit_res(op_h1, a_h1, b_h1); uf_h1 <= unit_ok(op_h1); end
      if (sel_h4 == 3'b001) begin ur_h4 <= unit_res(op_h4, a_h4, b_h4); uf_h4 <= unit_ok(op_h4); end
    end
  end

  // ---------------- reference model for the scoreboard ----------------
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  // Response contents from the operation's meaning: ADD/SUB modulo 256,
  // anything else is an error with a zero result.
  function automatic exp_t ref_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   s;
    e.op = op;
    case (op)
      4'h2:    begin s = (int'(a) + int'(b)) % 256;       e.res = 8'(s); e.err = 1'b0; end
      4'h3:    begin s = (int'(a) - int'(b) + 256) % 256; e.res = 8'(s); e.err = 1'b0; end
      default: begin e.res = 8'h00; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // ---------------- helpers ----------------
  typedef struct packed {
    logic       cmd_ready;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       rsp_valid;
    logic [7:0] rsp_result;
    logic [3:0] rsp_opcode;
    logic       rsp_error;
    logic       busy;
    logic [2:0] count;
  } obs_t;

  function automatic obs_t get_obs(input int which);
    obs_t o;
    case (which)
      1:       o = '{cr_h1, op_h1, a_h1, b_h1, sel_h1, rv_h1, rr_h1, ro_h1, re_h1, busy_h1, cnt_h1};
      2:       o = '{cr_h4, op_h4, a_h4, b_h4, sel_h4, rv_h4, rr_h4, ro_h4, re_h4, busy_h4, cnt_h4};
      default: o = '{cr_m,  op_m,  a_m,  b_m,  sel_m,  rv_m,  rr_m,  ro_m,  re_m,  busy_m,  cnt_m};
    endcase
    return o;
  endfunction

  task automatic set_valid(input int which, input logic v);
    case (which)
      1:       cv_h1 = v;
      2:       cv_h4 = v;
      default: cv_m  = v;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One cycle on the main instance with scoreboard bookkeeping. Inputs are
  // already applied; the handshakes seen now complete at the coming edge.
  task automatic step_main(output logic pushed);
    exp_t e;
    logic popped;
    pushed = cv_m && cr_m;
    popped = rv_m && rsp_ready;
    if (rv_m) check("select_zero_while_responding", 32'(sel_m), 32'd0);
    if (popped) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got opcode %0h result %0h, required no response", ro_m, rr_m);
      end else begin
        e = exp_q.pop_front();
        check("rsp_opcode", 32'(ro_m), 32'(e.op));
        check("rsp_result", 32'(rr_m), 32'(e.res));
        check("rsp_error",  32'(re_m), 32'(e.err));
      end
    end
    if (pushed) exp_q.push_back(ref_calc(cmd_opcode, cmd_a, cmd_b));
    tick();
  endtask

  // ---------------- directed single-op vectors ----------------
  typedef struct packed {
    logic [1:0] which;   // 0: HOLD 2, 1: HOLD 1, 2: HOLD 4
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  // Single op on an idle, empty instance with rsp_ready high: checks the
  // response latency, payload, Select window and the single handshake.
  task automatic run_op(input vec_t v);
    obs_t        o;
    int          hold;
    int          lat;
    int          vcycles;
    logic [10:0] selmask;
    logic [10:0] expmask;
    hold = (v.which == 2'd1) ? 1 : (v.which == 2'd2) ? 4 : 2;
    cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b; rsp_ready = 1'b1;
    set_valid(int'(v.which), 1'b1);
    o = get_obs(int'(v.which));
    check("cmd_ready_when_empty", 32'(o.cmd_ready), 32'd1);
    tick();                                   // edge t: command accepted
    set_valid(int'(v.which), 1'b0);
    lat = 0; vcycles = 0; selmask = '0; expmask = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();                                 // now just after edge t+c
      o = get_obs(int'(v.which));
      if (c <= hold + 1) expmask[c] = 1'b1;
      selmask[c] = (o.sel == 3'b001);
      if (o.sel != 3'b001 && o.sel != 3'b000) selmask[0] = 1'b1;
      if (o.rsp_valid) begin
        vcycles++;
        if (lat == 0) begin
          lat = c;
          check("op_rsp_result", 32'(o.rsp_result), 32'(v.res));
          check("op_rsp_error",  32'(o.rsp_error),  32'(v.err));
          check("op_rsp_opcode", 32'(o.rsp_opcode), 32'(v.op));
        end
      end
    end
    $display("op which=%0d opcode=%0h a=%0h b=%0h -> latency %0d result %0h error %0b",
             v.which, v.op, v.a, v.b, lat, o.rsp_result, o.rsp_error);
    check("op_latency",        32'(lat),      32'(hold + 2));
    check("op_select_window",  32'(selmask),  32'(expmask));
    check("op_single_rsp",     32'(vcycles),  32'd1);
    check("op_idle_after",     32'({o.busy, o.count, o.sel}), 32'd0);
    check("op_operands_kept",  32'({o.opcode, o.a, o.b}), 32'({v.op, v.a, v.b}));
  endtask

  vec_t vecs[9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main_seq
    obs_t o;
    logic pushed;
    int   idx;
    int   nrsp;
    int   guard;
    logic saw;
    exp_t cmds[6];
    logic [3:0] bp_op[6];
    logic [7:0] bp_a[6];
    logic [7:0] bp_b[6];

    vecs[0] = '{2'd0, 4'h2, 8'h25, 8'h13, 8'h38, 1'b0};
    vecs[1] = '{2'd0, 4'h3, 8'h10, 8'h20, 8'hF0, 1'b0};
    vecs[2] = '{2'd0, 4'h2, 8'hFF, 8'h01, 8'h00, 1'b0};
    vecs[3] = '{2'd0, 4'hA, 8'h55, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{2'd0, 4'h2, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{2'd0, 4'h3, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[6] = '{2'd0, 4'hF, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vecs[7] = '{2'd1, 4'h2, 8'h25, 8'h13, 8'h38, 1'b0};
    vecs[8] = '{2'd2, 4'h2, 8'h25, 8'h13, 8'h38, 1'b0};

    Reset = 1'b1; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    cv_m = 1'b0; cv_h1 = 1'b0; cv_h4 = 1'b0;
    tick(); tick();

    // ---- reset state ----
    o = get_obs(0);
    check("reset_outputs_zero", 32'({o.opcode, o.a, o.b, o.sel, o.rsp_valid, o.rsp_result,
                                      o.rsp_opcode, o.rsp_error, o.busy}), 32'd0);
    check("reset_count", 32'(o.count), 32'd0);
    check("reset_cmd_ready", 32'(o.cmd_ready), 32'd1);
    $display("reset: count=%0d cmd_ready=%0b busy=%0b", o.count, o.cmd_ready, o.busy);
    Reset = 1'b0;
    tick();

    // ---- table-driven single operations ----
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i]);
      tick();
    end

    // ---- backpressure: 6 commands offered with rsp_ready low ----
    for (int i = 0; i < 6; i++) begin
      bp_op[i] = (i % 3 == 2) ? 4'h5 : ((i % 2 == 0) ? 4'h2 : 4'h3);
      bp_a[i]  = 8'(17 * (i + 1) + 8'hC0);
      bp_b[i]  = 8'(3 * i + 8'h40);
      cmds[i]  = ref_calc(bp_op[i], bp_a[i], bp_b[i]);
    end
    rsp_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      cv_m = (idx < 6);
      if (idx < 6) begin cmd_opcode = bp_op[idx]; cmd_a = bp_a[idx]; cmd_b = bp_b[idx]; end
      step_main(pushed);
      if (pushed) begin
        $display("bp push %0d opcode=%0h a=%0h b=%0h", idx, bp_op[idx], bp_a[idx], bp_b[idx]);
        idx++;
      end
    end
    check("bp_accepted_while_stalled", 32'(idx), 32'd5);
    check("bp_count_full", 32'(cnt_m), 32'd4);
    check("bp_cmd_ready_low", 32'(cr_m), 32'd0);
    check("bp_stalled_rsp_valid", 32'(rv_m), 32'd1);
    check("bp_stalled_select", 32'(sel_m), 32'd0);
    check("bp_stalled_busy", 32'(busy_m), 32'd1);
    rsp_ready = 1'b1;
    nrsp = 0;
    guard = 0;
    while ((idx < 6 || exp_q.size() > 0) && guard < 80) begin
      cv_m = (idx < 6);
      if (idx < 6) begin cmd_opcode = bp_op[idx]; cmd_a = bp_a[idx]; cmd_b = bp_b[idx]; end
      if (rv_m) begin
        $display("bp rsp %0d opcode=%0h result=%0h error=%0b", nrsp, ro_m, rr_m, re_m);
        if (nrsp < 6) check("bp_rsp_order_opcode", 32'(ro_m), 32'(cmds[nrsp].op));
        nrsp++;
      end
      step_main(pushed);
      if (pushed) idx++;
      guard++;
    end
    cv_m = 1'b0;
    check("bp_all_accepted", 32'(idx), 32'd6);
    check("bp_all_responded", 32'(nrsp), 32'd6);
    check("bp_drained_count", 32'(cnt_m), 32'd0);

    // ---- randomized traffic against the scoreboard ----
    for (int k = 0; k < 400; k++) begin
      cv_m = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       cmd_opcode = 4'h3;
        1:       cmd_opcode = 4'($urandom);
        default: cmd_opcode = 4'h2;
      endcase
      cmd_a = 8'($urandom);
      cmd_b = 8'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      if (rv_m && rsp_ready)
        $display("rnd rsp opcode=%0h result=%0h error=%0b", ro_m, rr_m, re_m);
      step_main(pushed);
    end
    cv_m = 1'b0;
    rsp_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      if (rv_m) $display("rnd rsp opcode=%0h result=%0h error=%0b", ro_m, rr_m, re_m);
      step_main(pushed);
      guard++;
    end
    check("rnd_drain_done", 32'(exp_q.size()), 32'd0);
    check("rnd_idle_empty", 32'({busy_m, cnt_m}), 32'd0);

    // ---- asynchronous reset during ISSUE with 3 queued (HOLD 4 instance) ----
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cv_h4 = 1'b1; cmd_opcode = 4'h2; cmd_a = 8'(k + 1); cmd_b = 8'h10;
      tick();
    end
    cv_h4 = 1'b0;
    check("rst_pre_count", 32'(cnt_h4), 32'd3);
    check("rst_pre_issue_select", 32'(sel_h4), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    o = get_obs(2);
    check("rst_async_outputs_zero", 32'({o.opcode, o.a, o.b, o.sel, o.rsp_valid, o.busy}), 32'd0);
    check("rst_async_count", 32'(o.count), 32'd0);
    check("rst_async_main_result", 32'({rr_m, a_m, rv_m}), 32'd0);
    $display("reset mid-issue: count=%0d busy=%0b select=%0h", o.count, o.busy, o.sel);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    rsp_ready = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rv_h4 || busy_h4 || cnt_h4 != 3'd0) saw = 1'b1;
    end
    check("rst_no_response_after", 32'(saw), 32'd0);
    run_op(vecs[0]);
    tick();
    run_op(vecs[8]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
